// File: rtl/bsg_lane_permute_buf.sv
// Lane permutation stage with a 2-entry ready/valid output buffer.
// Each beat is permuted at enqueue and stored together with its swapped flag.
module bsg_lane_permute_buf #(
   parameter int width_p = 32,
   parameter int lanes_p = 4
) (
   input  logic               clk_i,
   input  logic               reset_i,
   input  logic               v_i,
   input  logic [width_p-1:0] data_i,
   input  logic [1:0]         mode_i,
   output logic               ready_o,
   output logic               v_o,
   output logic [width_p-1:0] data_o,
   output logic               swapped_o,
   input  logic               yumi_i
);

   localparam int lw = width_p / lanes_p;
   localparam int half = lanes_p / 2;

   if ((lanes_p < 2) || (lanes_p % 2 != 0) || (width_p % lanes_p != 0)) begin : g_bad
      $error("bsg_lane_permute_buf: lanes_p must be even, >=2 and divide width_p");
   end

   logic [width_p-1:0] half_w;
   logic [width_p-1:0] rev_w;

   for (genvar j = 0; j < lanes_p; j++) begin : g_lane
      assign half_w[j*lw +: lw] = data_i[((j + half) % lanes_p)*lw +: lw];
      assign rev_w[j*lw +: lw]  = data_i[(lanes_p - 1 - j)*lw +: lw];
   end

   logic               toggle_r;
   logic [width_p-1:0] perm_data;
   logic               perm_sw;

   always_comb begin
      perm_data = data_i;
      perm_sw   = 1'b0;
      unique case (mode_i)
         2'd0: begin
            perm_data = data_i;
            perm_sw   = 1'b0;
         end
         2'd1: begin
            perm_data = half_w;
            perm_sw   = 1'b1;
         end
         2'd2: begin
            perm_data = rev_w;
            perm_sw   = 1'b1;
         end
         2'd3: begin
            perm_data = toggle_r ? half_w : data_i;
            perm_sw   = toggle_r;
         end
         default: begin
            perm_data = data_i;
            perm_sw   = 1'b0;
         end
      endcase
   end

   logic [width_p-1:0] mem_data_r [2];
   logic [1:0]         mem_sw_r;
   logic               wr_ptr_r;
   logic               rd_ptr_r;
   logic               full_r;
   logic               empty_r;
   logic               enq;
   logic               deq;

   // ready_o deliberately ignores yumi_i so there is no comb path through the buffer
   assign enq = v_i & ~full_r;
   assign deq = yumi_i & ~empty_r;

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         mem_data_r[0] <= '0;
         mem_data_r[1] <= '0;
         mem_sw_r      <= '0;
         wr_ptr_r      <= 1'b0;
         rd_ptr_r      <= 1'b0;
         full_r        <= 1'b0;
         empty_r       <= 1'b1;
         toggle_r      <= 1'b0;
      end else begin
         if (enq) begin
            mem_data_r[wr_ptr_r] <= perm_data;
            mem_sw_r[wr_ptr_r]   <= perm_sw;
            wr_ptr_r             <= ~wr_ptr_r;
            if (mode_i == 2'd3) begin
               toggle_r <= ~toggle_r;
            end
         end
         if (deq) begin
            rd_ptr_r <= ~rd_ptr_r;
         end
         unique case ({enq, deq})
            2'b10: begin
               empty_r <= 1'b0;
               full_r  <= ~empty_r;
            end
            2'b01: begin
               full_r  <= 1'b0;
               empty_r <= ~full_r;
            end
            default: begin
               full_r  <= full_r;
               empty_r <= empty_r;
            end
         endcase
      end
   end

   assign ready_o   = ~full_r;
   assign v_o       = ~empty_r;
   assign data_o    = mem_data_r[rd_ptr_r];
   assign swapped_o = mem_sw_r[rd_ptr_r];

`ifndef SYNTHESIS
   a_yumi_valid: assert property (@(posedge clk_i) disable iff (reset_i)
      !(yumi_i && !v_o))
      else $error("bsg_lane_permute_buf: yumi_i asserted with v_o low");

   a_mode_known: assert property (@(posedge clk_i) disable iff (reset_i)
      !(v_i && $isunknown(mode_i)))
      else $error("bsg_lane_permute_buf: mode_i unknown while v_i high");
`endif

endmodule

// File: tb/tb_bsg_lane_permute_buf.sv
// Bench for bsg_lane_permute_buf: table vectors, hand sequences and
// randomized traffic against a queue-based reference model.
module tb_bsg_lane_permute_buf;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset_i;
   logic        v_i;
   logic [31:0] data_i;
   logic [1:0]  mode_i;
   logic        yumi_i;
   logic        ready_o;
   logic        v_o;
   logic [31:0] data_o;
   logic        swapped_o;

   logic        v16_i;
   logic [15:0] data16_i;
   logic [1:0]  mode16_i;
   logic        yumi16_i;
   logic        ready16_o;
   logic        v16_o;
   logic [15:0] data16_o;
   logic        swapped16_o;

   bsg_lane_permute_buf #(.width_p(32), .lanes_p(4)) dut (
      .clk_i(clk), .reset_i(reset_i), .v_i(v_i), .data_i(data_i),
      .mode_i(mode_i), .ready_o(ready_o), .v_o(v_o), .data_o(data_o),
      .swapped_o(swapped_o), .yumi_i(yumi_i)
   );

   bsg_lane_permute_buf #(.width_p(16), .lanes_p(2)) dut16 (
      .clk_i(clk), .reset_i(reset_i), .v_i(v16_i), .data_i(data16_i),
      .mode_i(mode16_i), .ready_o(ready16_o), .v_o(v16_o), .data_o(data16_o),
      .swapped_o(swapped16_o), .yumi_i(yumi16_i)
   );

   int n_vec = 0;
   int n_err = 0;

   typedef struct {
      logic [31:0] d;
      logic        sw;
   } beat_t;

   beat_t q[$];
   bit    tog = 1'b0;

   typedef struct {
      logic [31:0] d;
      logic [1:0]  m;
      logic [31:0] exp_d;
      logic        exp_sw;
   } vec_t;

   function automatic logic [31:0] ref_perm(logic [31:0] d, int w, int l, int m);
      logic [31:0] r;
      int lw;
      int src;
      r = '0;
      lw = w / l;
      for (int j = 0; j < l; j++) begin
         if (m == 1) src = (j + l/2) % l;
         else if (m == 2) src = l - 1 - j;
         else src = j;
         for (int b = 0; b < lw; b++) r[j*lw + b] = d[src*lw + b];
      end
      return r;
   endfunction

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Called at a negedge; applies one beat across the next posedge.
   task automatic cycle(bit v, logic [31:0] d, logic [1:0] m, bit y);
      bit acc;
      bit dq;
      int em;
      beat_t b;
      if (q.size() > 0) begin
         check("head_data", data_o, q[0].d);
         check("head_sw", {31'b0, swapped_o}, {31'b0, q[0].sw});
      end
      dq = y && (q.size() > 0);
      acc = v && (q.size() < 2);
      v_i = v;
      data_i = d;
      mode_i = m;
      yumi_i = dq;
      if (dq) void'(q.pop_front());
      if (acc) begin
         em = m;
         b.sw = (m == 2'd1) || (m == 2'd2);
         if (m == 2'd3) begin
            em = tog ? 1 : 0;
            b.sw = tog;
            tog = ~tog;
         end
         b.d = ref_perm(d, 32, 4, em);
         q.push_back(b);
      end
      @(posedge clk);
      @(negedge clk);
      v_i = 1'b0;
      yumi_i = 1'b0;
      check("v_o", {31'b0, v_o}, {31'b0, q.size() > 0});
      check("ready_o", {31'b0, ready_o}, {31'b0, q.size() < 2});
   endtask

   vec_t tbl[7];

   initial begin
      tbl[0] = '{32'h44332211, 2'd0, 32'h44332211, 1'b0};
      tbl[1] = '{32'h44332211, 2'd1, 32'h22114433, 1'b1};
      tbl[2] = '{32'h44332211, 2'd2, 32'h11223344, 1'b1};
      tbl[3] = '{32'hAAAA5555, 2'd3, 32'hAAAA5555, 1'b0};
      tbl[4] = '{32'hAAAA5555, 2'd3, 32'h5555AAAA, 1'b1};
      tbl[5] = '{32'hAAAA5555, 2'd0, 32'hAAAA5555, 1'b0};
      tbl[6] = '{32'hAAAA5555, 2'd3, 32'hAAAA5555, 1'b0};

      reset_i = 1'b1;
      v_i = 1'b0; data_i = '0; mode_i = '0; yumi_i = 1'b0;
      v16_i = 1'b0; data16_i = '0; mode16_i = '0; yumi16_i = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("rst_v_o", {31'b0, v_o}, 32'd0);
      check("rst_ready_o", {31'b0, ready_o}, 32'd1);
      check("rst_v16_o", {31'b0, v16_o}, 32'd0);
      reset_i = 1'b0;
      @(negedge clk);

      // single beats through an empty buffer
      for (int i = 0; i < 7; i++) begin
         cycle(1'b1, tbl[i].d, tbl[i].m, 1'b0);
         check("tbl_v", {31'b0, v_o}, 32'd1);
         check("tbl_data", data_o, tbl[i].exp_d);
         check("tbl_sw", {31'b0, swapped_o}, {31'b0, tbl[i].exp_sw});
         cycle(1'b0, '0, 2'd0, 1'b1);
      end

      // backpressure: third beat held while full
      cycle(1'b1, 32'h1, 2'd0, 1'b0);
      cycle(1'b1, 32'h2, 2'd0, 1'b0);
      check("full_ready", {31'b0, ready_o}, 32'd0);
      cycle(1'b1, 32'h3, 2'd0, 1'b0);
      check("held_head", data_o, 32'h1);
      cycle(1'b1, 32'h3, 2'd0, 1'b1);
      check("ready_after_deq", {31'b0, ready_o}, 32'd1);
      cycle(1'b1, 32'h3, 2'd0, 1'b1);
      check("third_head", data_o, 32'h3);
      cycle(1'b0, '0, 2'd0, 1'b1);

      // streaming at full rate
      for (int i = 0; i < 16; i++) begin
         cycle(1'b1, 32'd100 + i, 2'd0, q.size() > 0);
         check("stream_v", {31'b0, v_o}, 32'd1);
      end
      cycle(1'b0, '0, 2'd0, 1'b1);

      // reset while full with toggle set
      cycle(1'b1, 32'hA, 2'd3, 1'b0);
      cycle(1'b1, 32'hB, 2'd0, 1'b0);
      #2 reset_i = 1'b1;
      #1;
      check("midrst_v_o", {31'b0, v_o}, 32'd0);
      check("midrst_ready", {31'b0, ready_o}, 32'd1);
      q.delete();
      tog = 1'b0;
      @(negedge clk);
      reset_i = 1'b0;
      cycle(1'b1, 32'h12345678, 2'd3, 1'b0);
      check("postrst_data", data_o, 32'h12345678);
      check("postrst_sw", {31'b0, swapped_o}, 32'd0);
      cycle(1'b0, '0, 2'd0, 1'b1);

      // randomized traffic
      for (int i = 0; i < 400; i++) begin
         cycle($urandom_range(0, 1) == 1, $urandom, 2'($urandom_range(0, 3)),
               $urandom_range(0, 1) == 1);
      end
      while (q.size() > 0) cycle(1'b0, '0, 2'd0, 1'b1);

      // two-lane instance: half swap and reverse coincide
      for (int m = 1; m <= 2; m++) begin
         v16_i = 1'b1;
         data16_i = 16'hBEEF;
         mode16_i = 2'(m);
         @(posedge clk);
         @(negedge clk);
         v16_i = 1'b0;
         check("l2_v", {31'b0, v16_o}, 32'd1);
         check("l2_data", {16'b0, data16_o}, 32'h0000EFBE);
         check("l2_sw", {31'b0, swapped16_o}, 32'd1);
         yumi16_i = 1'b1;
         @(posedge clk);
         @(negedge clk);
         yumi16_i = 1'b0;
         check("l2_empty", {31'b0, v16_o}, 32'd0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/bsg_lane_permute_buf.md
Name: bsg_lane_permute_buf

Overview:
Parametrised, buffered successor to the fixed 32-bit half-swap mux. It splits a data word into lanes_p equal lanes and permutes them per beat according to a mode field:
- pass-through
- half swap
- full lane reverse
- alternating half swap, driven by an internal toggle

Results are registered into a 2-entry ready/valid buffer, so the block sits directly on a streaming datapath between a producer and consumer with full-throughput flow control.

Parameters:
- width_p, 32, total data width in bits.
- lanes_p, 4, number of lanes. Must be even, ≥2, and divide width_p. Lane width lw = width_p/lanes_p.

Ports:
- clk_i  input  1  clock.
- reset_i  input  1  reset.
- v_i  input  1  input beat valid.
- data_i  input  width_p  input word; lane k = data_i[k*lw +: lw].
- mode_i  input  2  permutation select for this beat; sampled with v_i.
- ready_o  output  1  block can accept a beat this cycle.
- v_o  output  1  output beat valid.
- data_o  output  width_p  permuted word at buffer head.
- swapped_o  output  1  head beat had a non-identity permutation applied.
- yumi_i  input  1  consumer takes head beat; legal only when v_o=1.

Behaviour:
- Clocking: one clock, clk_i. reset_i is asynchronous, active-high.
- Reset values: buffer empty, v_o=0, data_o=0, swapped_o=0, ready_o=1, toggle_r=0, rd/wr pointers=0.
- Handshake:
  - Enqueue when v_i & ready_o.
  - Dequeue when yumi_i.
  - ready_o = ~full; it is not a function of yumi_i (no same-cycle pass-through when full).
- Permutation is computed combinationally at enqueue and stored. The output lane is out[j]:
  - mode 0 pass: out[j] = in[j].
  - mode 1 half swap: out[j] = in[(j + lanes_p/2) mod lanes_p].
  - mode 2 reverse: out[j] = in[lanes_p-1-j].
  - mode 3 alternate: apply the mode 1 permutation iff toggle_r=1, else pass.
    - toggle_r flips on every enqueued mode-3 beat.
    - Beats in modes 0–2 leave toggle_r unchanged.
- swapped_o stored per entry:
  - 1 for modes 1 and 2.
  - For mode 3, equal to the toggle_r value used for that beat.
  - 0 for mode 0.
- Latency: a beat enqueued in cycle N is visible on v_o/data_o in cycle N+1 if the buffer was empty. There is no combinational path from input to output.
- Storage: 2-entry circular buffer with 1-bit read and write pointers, plus a full/empty flag pair.
  - Enqueue only: empty→one, one→full.
  - Dequeue only: full→one, one→empty.
  - Simultaneous enqueue and dequeue with one entry: occupancy stays one; the new beat becomes head next cycle. Sustains 1 beat/cycle.
  - Full: ready_o=0; v_i is ignored and its mode-3 toggle effect is not applied.
- Order: strict FIFO; data_o and swapped_o always reflect the head entry.
- v_o=0: data_o and swapped_o are don't-care. The bench must not check them.
- Reset mid-operation: all stored beats are discarded immediately (asynchronously) and toggle_r is cleared. The first mode-3 beat after reset is unswapped.
- Protocol assertions (simulation only):
  - yumi_i & ~v_o is an error.
  - X on mode_i while v_i is high is an error.
- Degenerate case lanes_p=2: mode 1 and mode 2 give identical output.

Test Plan:
1. width_p=32, lanes_p=4, data_i=0x44332211 → mode 0 → data_o 0x44332211, swapped_o 0; mode 1 → 0x22114433, swapped_o 1; mode 2 → 0x11223344, swapped_o 1; each has v_o high the cycle after enqueue.
2. Three mode-3 beats of 0xAAAA5555, with a mode-0 beat inserted between the 2nd and 3rd → outputs 0xAAAA5555 (swapped_o 0), 0x5555AAAA (1), 0xAAAA5555 (0, mode 0), 0xAAAA5555 (0); this shows mode 0 does not flip the toggle.
3. Hold yumi_i=0 and present 3 beats back-to-back (0x1,0x2,0x3, mode 0) → ready_o drops after 2 accepts and the 3rd is held by the producer; then assert yumi_i each cycle → outputs 0x1,0x2,0x3 in order; ready_o returns high the cycle after the first dequeue.
4. Continuous v_i=1 and yumi_i=1 for 16 cycles with incrementing data → one output per cycle, no bubbles after the first, ready_o stays 1.
5. Buffer full, with toggle_r=1 from one prior mode-3 beat, then assert reset_i mid-cycle → v_o=0 and ready_o=1 immediately; after release, a mode-3 beat 0x12345678 → 0x12345678, swapped_o 0.
6. width_p=16, lanes_p=2, data 0xBEEF → modes 1 and 2 both give 0xEFBE.
